// File: rtl/lsu_pkg.sv
// lsu_pkg: op encodings, response metadata and lane helpers for lsu_obi_pipelined
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam int         OP_STORE = 3;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] off;
        logic       periph;
    } meta_t;

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = off[1] ? rdata[31:16] : off[0] ? rdata[23:8] : rdata[15:0];
        return f3 == F3_B  ? {{24{b[7]}}, b} :
               f3 == F3_BU ? {24'h0, b} :
               f3 == F3_H  ? {{16{h[15]}}, h} :
               f3 == F3_HU ? {16'h0, h} : rdata;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        return f3 == F3_B ? 4'b0001 << off : f3 == F3_H ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
        return f3 == F3_B ? {4{wdata[7:0]}} : f3 == F3_H ? {2{wdata[15:0]}} : wdata;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return (f3[1:0] == 2'b01 && off[0]) || (f3 == F3_W && off != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_meta_fifo.sv
// lsu_meta_fifo: synchronous FIFO with full/empty/count and same-cycle push/pop
module lsu_meta_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= inc(wptr_q);
            if (do_pop) rptr_q <= inc(rptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end
endmodule

// File: rtl/lsu_obi_pipelined.sv
// lsu_obi_pipelined: pipelined OBI load/store unit with in-order tagged responses
// Define LSU_MISALIGN_CHECK_EN to reject misaligned halfword/word accesses with rsp_err_o.
module lsu_obi_pipelined
    import lsu_pkg::*;
#(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          TAG_W           = 5,
    parameter logic [31:0] PERIPH_MIN      = 32'h0000_2600,
    parameter logic [31:0] PERIPH_MAX      = 32'h0000_2800
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic [3:0]                           req_op_i,
    input  logic [31:0]                          req_addr_i,
    input  logic [31:0]                          req_wdata_i,
    input  logic [TAG_W-1:0]                     req_tag_i,
    output logic                                 rsp_valid_o,
    output logic [31:0]                          rsp_data_o,
    output logic [TAG_W-1:0]                     rsp_tag_o,
    output logic                                 rsp_store_o,
    output logic                                 rsp_periph_o,
    output logic                                 rsp_err_o,
    output logic                                 data_req_o,
    output logic                                 data_we_o,
    output logic [31:0]                          data_addr_o,
    output logic [3:0]                           data_be_o,
    output logic [31:0]                          data_wdata_o,
    input  logic                                 data_gnt_i,
    input  logic                                 data_rvalid_i,
    input  logic [31:0]                          data_rdata_i,
    output logic                                 idle_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 protocol_err_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int MW = TAG_W + $bits(meta_t);

    logic             hold_valid_q, hold_periph_q, hold_mis;
    logic [3:0]       hold_op_q;
    logic [31:0]      hold_addr_q, hold_wdata_q;
    logic [TAG_W-1:0] hold_tag_q, head_tag, err_tag_q;
    logic             accept, gnt_fire, pop, drain, err_q, fifo_full, fifo_empty, protocol_err_q;
    logic [CW-1:0]    occ;
    logic [MW-1:0]    push_data, head_data;
    meta_t            head;

    assign data_req_o  = hold_valid_q && !hold_mis;
    assign gnt_fire    = data_req_o && data_gnt_i;
    assign pop         = data_rvalid_i && !fifo_empty;
    assign occ         = outstanding_o - CW'(pop);
    // a response retiring this cycle frees its slot for the next accept
    assign req_ready_o = (!hold_valid_q || gnt_fire) && (32'(occ) + 32'(hold_valid_q) < MAX_OUTSTANDING)
                         && (!fifo_full || pop);
    assign accept      = req_valid_i && req_ready_o;

`ifdef LSU_MISALIGN_CHECK_EN
    assign hold_mis = hold_valid_q && misaligned(hold_op_q[2:0], hold_addr_q[1:0]);
    assign drain    = hold_mis && occ == '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q     <= 1'b0;
            err_tag_q <= '0;
        end else begin
            err_q     <= drain;
            err_tag_q <= hold_tag_q;
        end
    end
`else
    assign hold_mis  = 1'b0;
    assign drain     = 1'b0;
    assign err_q     = 1'b0;
    assign err_tag_q = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid_q  <= 1'b0;
            hold_op_q     <= '0;
            hold_addr_q   <= '0;
            hold_wdata_q  <= '0;
            hold_tag_q    <= '0;
            hold_periph_q <= 1'b0;
        end else if (accept) begin
            hold_valid_q  <= 1'b1;
            hold_op_q     <= req_op_i;
            hold_addr_q   <= req_addr_i;
            hold_wdata_q  <= req_wdata_i;
            hold_tag_q    <= req_tag_i;
            hold_periph_q <= req_addr_i >= PERIPH_MIN && req_addr_i < PERIPH_MAX;
        end else if (gnt_fire || drain) begin
            hold_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) protocol_err_q <= 1'b0;
        else if (data_rvalid_i && fifo_empty) protocol_err_q <= 1'b1;
    end

    assign data_we_o    = data_req_o && hold_op_q[OP_STORE];
    assign data_addr_o  = {hold_addr_q[31:2], 2'b00};
    assign data_be_o    = !data_req_o ? 4'b0000 : data_we_o ? store_be(hold_op_q[2:0], hold_addr_q[1:0]) : 4'b1111;
    assign data_wdata_o = data_we_o ? store_data(hold_op_q[2:0], hold_wdata_q) : '0;

    assign push_data = {hold_tag_q, hold_op_q, hold_addr_q[1:0], hold_periph_q};
    assign {head_tag, head} = head_data;

    lsu_meta_fifo #(.DEPTH(MAX_OUTSTANDING), .W(MW)) u_meta (
        .clk     (clk),
        .reset   (reset),
        .push_i  (gnt_fire),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

    assign rsp_valid_o    = pop || err_q;
    assign rsp_data_o     = pop && !head.op[OP_STORE] ? load_extract(head.op[2:0], head.off, data_rdata_i) : '0;
    assign rsp_tag_o      = pop ? head_tag : err_q ? err_tag_q : '0;
    assign rsp_store_o    = pop && head.op[OP_STORE];
    assign rsp_periph_o   = pop && head.periph;
    assign rsp_err_o      = err_q;
    assign idle_o         = !hold_valid_q && fifo_empty && !err_q;
    assign protocol_err_o = protocol_err_q;
endmodule

// File: tb/tb_lsu_obi_pipelined.sv
// tb_lsu_obi_pipelined: directed self-checking bench for lsu_obi_pipelined
module tb_lsu_obi_pipelined;
    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [4:0]  req_tag = '0;
    logic        rsp_valid, rsp_store, rsp_periph, rsp_err;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic        data_req, data_we, data_gnt = 1'b0, data_rvalid = 1'b0;
    logic [31:0] data_addr, data_wdata, data_rdata = '0;
    logic [3:0]  data_be;
    logic        idle, protocol_err;
    logic [1:0]  outstanding;
    int          n_pass = 0, n_checks = 0;

    always #5 clk = ~clk;

    lsu_obi_pipelined dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_tag_i      (req_tag),
        .rsp_valid_o    (rsp_valid),
        .rsp_data_o     (rsp_data),
        .rsp_tag_o      (rsp_tag),
        .rsp_store_o    (rsp_store),
        .rsp_periph_o   (rsp_periph),
        .rsp_err_o      (rsp_err),
        .data_req_o     (data_req),
        .data_we_o      (data_we),
        .data_addr_o    (data_addr),
        .data_be_o      (data_be),
        .data_wdata_o   (data_wdata),
        .data_gnt_i     (data_gnt),
        .data_rvalid_i  (data_rvalid),
        .data_rdata_i   (data_rdata),
        .idle_o         (idle),
        .outstanding_o  (outstanding),
        .protocol_err_o (protocol_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input string nm, input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [4:0] tag, input logic [3:0] be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rsp, input logic periph);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_tag = tag;
        #1 check({nm, " ready"}, req_ready, 1);
        cyc();
        req_valid = 1'b0; data_gnt = 1'b1;
        #1 check({nm, " req"}, data_req, 1);
        check({nm, " we"}, data_we, op[3]);
        check({nm, " addr"}, data_addr, {addr[31:2], 2'b00});
        check({nm, " be"}, data_be, be);
        check({nm, " wdata"}, data_wdata, exp_wdata);
        cyc();
        data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = rdata;
        #1 check({nm, " rsp_valid"}, rsp_valid, 1);
        check({nm, " rsp_data"}, rsp_data, exp_rsp);
        check({nm, " rsp_tag"}, rsp_tag, tag);
        check({nm, " rsp_store"}, rsp_store, op[3]);
        check({nm, " rsp_periph"}, rsp_periph, periph);
        check({nm, " rsp_err"}, rsp_err, 0);
        cyc();
        data_rvalid = 1'b0;
    endtask

    initial begin
        cyc(); cyc();
        check("rst ready", req_ready, 1);
        check("rst idle", idle, 1);
        check("rst req", data_req, 0);
        check("rst be", data_be, 0);
        check("rst rsp_valid", rsp_valid, 0);
        check("rst outstanding", outstanding, 0);
        check("rst proto", protocol_err, 0);
        reset = 1'b0;

        access("lw",  4'b0010, 32'h2800, 32'h0,        32'hDEADBEEF, 5'd5,  4'b1111, 32'h0,        32'hDEADBEEF, 1'b0);
        access("lb",  4'b0000, 32'h2603, 32'h0,        32'h80112233, 5'd6,  4'b1111, 32'h0,        32'hFFFFFF80, 1'b1);
        access("lbu", 4'b0100, 32'h2603, 32'h0,        32'h80112233, 5'd7,  4'b1111, 32'h0,        32'h00000080, 1'b1);
        access("sb",  4'b1000, 32'h2802, 32'hAB,       32'h0,        5'd8,  4'b0100, 32'hABABABAB, 32'h0,        1'b0);
        access("lh",  4'b0001, 32'h2602, 32'h0,        32'h80011234, 5'd9,  4'b1111, 32'h0,        32'hFFFF8001, 1'b1);
        access("lhu", 4'b0101, 32'h2600, 32'h0,        32'h1234ABCD, 5'd10, 4'b1111, 32'h0,        32'h0000ABCD, 1'b1);
        access("sh",  4'b1001, 32'h27FE, 32'h12345678, 32'h0,        5'd11, 4'b1100, 32'h56785678, 32'h0,        1'b1);
        access("sw",  4'b1010, 32'h25FC, 32'hCAFEF00D, 32'h0,        5'd12, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0);
`ifndef LSU_MISALIGN_CHECK_EN
        access("lh1", 4'b0001, 32'h2601, 32'h0,        32'h00ABCD00, 5'd13, 4'b1111, 32'h0,        32'hFFFFABCD, 1'b1);
        access("sh1", 4'b1001, 32'h2001, 32'h5678,     32'h0,        5'd14, 4'b0011, 32'h56785678, 32'h0,        1'b0);
`endif

        req_valid = 1'b1; req_op = 4'b0010; req_addr = 32'h100; req_tag = 5'd1; data_gnt = 1'b1;
        #1 check("pipe ready0", req_ready, 1);
        cyc();
        req_addr = 32'h104; req_tag = 5'd2;
        #1 check("pipe ready1", req_ready, 1);
        check("pipe addr_a", data_addr, 32'h100);
        cyc();
        req_addr = 32'h108; req_tag = 5'd3;
        #1 check("pipe ready2", req_ready, 0);
        check("pipe out1", outstanding, 1);
        check("pipe addr_b", data_addr, 32'h104);
        cyc();
        req_valid = 1'b0;
        #1 check("pipe out2", outstanding, 2);
        check("pipe full ready", req_ready, 0);
        check("pipe no req", data_req, 0);
        cyc(); cyc();
        check("pipe still 2", outstanding, 2);
        data_rvalid = 1'b1; data_rdata = 32'h11111111;
        #1 check("pipe rsp1 tag", rsp_tag, 1);
        check("pipe rsp1 data", rsp_data, 32'h11111111);
        cyc();
        data_rdata = 32'h22222222;
        #1 check("pipe rsp2 tag", rsp_tag, 2);
        check("pipe rsp2 data", rsp_data, 32'h22222222);
        cyc();
        data_rvalid = 1'b0; data_gnt = 1'b0;
        #1 check("pipe drained", outstanding, 0);
        check("pipe idle", idle, 1);

        req_valid = 1'b1; req_op = 4'b1001; req_addr = 32'h2802; req_wdata = 32'hBEEF; req_tag = 5'd7;
        cyc();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall req", data_req, 1);
            check("stall addr", data_addr, 32'h2800);
            check("stall be", data_be, 4'b1100);
            check("stall wdata", data_wdata, 32'hBEEFBEEF);
            cyc();
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1 check("midrst req", data_req, 0);
        check("midrst idle", idle, 1);
        check("midrst ready", req_ready, 1);

        data_rvalid = 1'b1;
        #1 check("stray rsp_valid", rsp_valid, 0);
        cyc();
        data_rvalid = 1'b0;
        #1 check("proto set", protocol_err, 1);
        cyc();
        check("proto sticky", protocol_err, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1 check("proto clear", protocol_err, 0);

`ifdef LSU_MISALIGN_CHECK_EN
        req_valid = 1'b1; req_op = 4'b0010; req_addr = 32'h2900; req_tag = 5'd3;
        cyc();
        req_addr = 32'h2801; req_tag = 5'd9; data_gnt = 1'b1;
        #1 check("mis ready", req_ready, 1);
        cyc();
        req_valid = 1'b0; data_gnt = 1'b0;
        #1 check("mis no req", data_req, 0);
        check("mis out", outstanding, 1);
        cyc();
        data_rvalid = 1'b1; data_rdata = 32'h5;
        #1 check("mis first tag", rsp_tag, 3);
        check("mis first err", rsp_err, 0);
        cyc();
        data_rvalid = 1'b0;
        #1 check("mis err valid", rsp_valid, 1);
        check("mis err", rsp_err, 1);
        check("mis err tag", rsp_tag, 9);
        check("mis err data", rsp_data, 0);
        check("mis err req", data_req, 0);
        cyc();
        check("mis idle", idle, 1);
        check("mis done", rsp_valid, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/lsu_obi_pipelined.md
# lsu_obi_pipelined

Parametrised load/store unit between the execute stage and the OBI-style data bus (req/gnt/rvalid). It replaces the single-transaction data-memory FSM. Up to MAX_OUTSTANDING granted transactions can be in flight, and a tagged metadata queue returns responses in order. It performs byte-lane steering for stores, sign/zero extension for loads, and peripheral-window classification.

## Interface
- MAX_OUTSTANDING, 2: in-flight granted transactions allowed (1..8)
- TAG_W, 5: width of the caller tag returned with each response (rd index)
- PERIPH_MIN, 32'h0000_2600: peripheral window start, inclusive
- PERIPH_MAX, 32'h0000_2800: peripheral window end, exclusive
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid_i  in  1  execute presents an access
- req_ready_o  out  1  access accepted when valid&&ready
- req_op_i  in  4  {is_store, funct3}: LB/LH/LW/LBU/LHU, SB/SH/SW
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned
- req_tag_i  in  TAG_W  caller tag
- rsp_valid_o  out  1  one response this cycle
- rsp_data_o  out  32  extended load data; 0 for stores and errors
- rsp_tag_o  out  TAG_W  tag of the responding access
- rsp_store_o  out  1  response belongs to a store
- rsp_periph_o  out  1  address was in [PERIPH_MIN, PERIPH_MAX)
- rsp_err_o  out  1  misaligned access, not issued (macro only)
- data_req_o, data_we_o  out  1  bus request / write
- data_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  lane-steered store data
- data_gnt_i, data_rvalid_i  in  1  grant / response valid
- data_rdata_i  in  32  read word
- idle_o  out  1  no held request, queue empty
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  granted-not-responded count
- protocol_err_o  out  1  sticky: data_rvalid_i seen with outstanding_o==0

## Operation
- Hold register: one accepted request. data_req_o = hold_valid_q && ~hold_misaligned. Bus outputs come from hold registers only, so they are stable until granted.
- req_ready_o = (~hold_valid_q || (data_req_o && data_gnt_i)) && (outstanding + hold_valid_q < MAX_OUTSTANDING).
- On grant: push {op, addr[1:0], tag, periph} into the metadata queue, outstanding+1. If no new request is accepted in the same cycle, hold empties.
- On data_rvalid_i: pop the head. rsp_valid_o=1 the same cycle (combinational from rdata). Loads extract the byte/half at the head offset and sign/zero extend. Stores return rsp_data_o=0.
- Push and pop in the same cycle: count unchanged. Push never exceeds MAX_OUTSTANDING.
- Store steering: SB → be=1<<off, data replicated byte. SH → be=off[1]?1100:0011. SW → 1111. Loads → be=1111, we=0.
- rvalid with empty queue: ignored, protocol_err_o set until reset.
- reset: hold and queue cleared, count 0. All outputs 0 except req_ready_o=1 and idle_o=1. Bus responses to pre-reset requests are not tracked.

## Timing
- Accept cycle N → data_req_o at N+1 → earliest rvalid/rsp_valid_o at N+2.
- Sustained 1 access/cycle when gnt is tied high, rvalid is one cycle later, and MAX_OUTSTANDING ≥ 2.
- data_req_o stays asserted with constant addr/be/wdata until data_gnt_i.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]≠0 are flagged misaligned. The request stays in hold without a bus request until the queue is empty, then produces rsp_valid_o=1, rsp_err_o=1 and its tag the next cycle. No bus transaction is issued.
- Undefined: rsp_err_o tied 0. LW/SW ignore addr[1:0]. Halfword at offset 1 uses bytes [23:8] for loads and lanes 0-1 for stores, matching the previous unit's behaviour.

## Structure
- Package lsu_pkg: op encodings (funct3 values, store bit), meta struct, extraction/steering functions.
- Sub-module lsu_meta_fifo: synchronous FIFO, depth MAX_OUTSTANDING, with full/empty/count and simultaneous push/pop support.

## Test plan
- LW 0x2800 with gnt immediate, rvalid+1, rdata=0xDEADBEEF → rsp_data_o=0xDEADBEEF, rsp_tag_o echoed, rsp_periph_o=0.
- LB 0x2603 with rdata=0x80112233 → rsp_data_o=0xFFFFFF80, rsp_periph_o=1. LBU at the same address → 0x00000080.
- SB 0x2802 wdata=0xAB → data_be_o=0100, data_wdata_o bits[23:16]=0xAB, data_we_o=1. The response has rsp_store_o=1.
- MAX_OUTSTANDING=2, gnt held high, rvalid withheld for 4 cycles → outstanding_o reaches 2 and req_ready_o=0. Releasing rvalid returns the responses in acceptance order.
- gnt held low 3 cycles → data_req_o/addr/be stable for all 3 cycles. Reset asserted mid-wait → data_req_o=0 and idle_o=1 the cycle after reset.
- With LSU_MISALIGN_CHECK_EN, LW 0x2801 after one pending load → no bus request. rsp_err_o=1 the cycle after the pending load completes.
